vc_pop_arbiter: RTL and testbench
=================================

// Module: vc_pop_arbiter
// PURPOSE
// Read-side end of the VC0/VC1 virtual-channel FIFOs in the PCI transmission layer.
// Pops words from the VC0/VC1 FIFOs, VC0 having priority, and routes each word to
// destination FIFO D0 or D1 by a destination bit. Stops popping while either
// destination asserts pause (its almost-full flag).
// Also counts words forwarded per VC.
// PARAMETERS
// DATA_WIDTH    6   word width, identical on VC FIFOs and destination FIFOs
// DEST_BIT      4   bit index of the word that selects destination (0->D0, 1->D1)
// CNT_WIDTH     8   width of per-VC forwarded-word counters
// STARVE_LIMIT  4   consecutive VC0 pops before a forced VC1 pop (VC1_STARVE_GUARD_EN only)
// PORTS
// clk           in   1           single clock, all state on rising edge
// reset         in   1           synchronous, active-high
// vc0_empty     in   1           VC0 FIFO empty
// vc0_data      in   DATA_WIDTH  VC0 FIFO read data, valid the cycle after pop_vc0
// vc1_empty     in   1           VC1 FIFO empty
// vc1_data      in   DATA_WIDTH  VC1 FIFO read data, valid the cycle after pop_vc1
// d0_pause      in   1           D0 FIFO almost-full
// d1_pause      in   1           D1 FIFO almost-full
// pop_vc0       out  1           pop strobe to VC0 FIFO (combinational)
// pop_vc1       out  1           pop strobe to VC1 FIFO (combinational)
// push_d0       out  1           push strobe to D0 FIFO (registered)
// push_d1       out  1           push strobe to D1 FIFO (registered)
// data_out      out  DATA_WIDTH  write data to D0/D1 (registered)
// cnt_vc0       out  CNT_WIDTH   words forwarded from VC0
// cnt_vc1       out  CNT_WIDTH   words forwarded from VC1
// idle          out  1           both VC FIFOs empty and no word in flight
// BEHAVIOUR
// - Single clock. Reset is synchronous and active-high.
// - Reset: pop_* = 0 (combinational gate). rd_valid, rd_src, push_*, data_out,
//   cnt_*, and the starve counter are all cleared to 0. idle = 1.
// - Reset mid-operation discards in-flight words. No push is issued on the cycle after reset.
// - pause_any = d0_pause | d1_pause.
// - pop_vc0 = !reset & !pause_any & !vc0_empty & !force_vc1.
// - pop_vc1 = !reset & !pause_any & !vc1_empty & (vc0_empty | force_vc1).
// - pop_vc0 and pop_vc1 are never high together. At most one pop per cycle.
// - Stage 1 (edge after pop cycle N): rd_valid <= pop_vc0|pop_vc1; rd_src <= pop_vc1.
// - Stage 2 (cycle N+1): sel = rd_src ? vc1_data : vc0_data.
//   If rd_valid, then at that edge:
//   data_out <= sel; push_d0 <= !sel[DEST_BIT]; push_d1 <= sel[DEST_BIT].
//   Otherwise push_* <= 0 and data_out holds its value.
// - Latency: pop in cycle N -> push_dX and data_out valid in cycle N+2. Full throughput is 1 word/cycle.
// - Pause: pops drop in the same cycle that pause_any rises. Up to 2 in-flight words still push.
//   Downstream almost-full thresholds must leave >= 2 free slots.
// - Counters: cnt_vc0/cnt_vc1 increment when a push is issued whose source is that VC.
//   They wrap from 2^CNT_WIDTH-1 to 0.
// - idle = vc0_empty & vc1_empty & !rd_valid & !push_d0 & !push_d1.
// CONFIGURATION
// - VC1_STARVE_GUARD_EN defined:
//   - The starve counter increments on each pop_vc0 while !vc1_empty.
//   - It clears on pop_vc1 or when vc1_empty.
//   - force_vc1 = (starve_cnt == STARVE_LIMIT) & !vc1_empty.
//   - Pause cycles leave the counter unchanged.
// - VC1_STARVE_GUARD_EN undefined: force_vc1 = 0, giving strict VC0 priority.
//   No starve counter is built.
// TESTING
// - Reset held 2 cycles with both FIFOs non-empty -> pop_*=0, push_*=0, data_out=0, cnt_*=0, idle=1.
// - VC0 holds 0x05 then 0x12, no pause -> pop_vc0 in cycles 1,2;
//   push_d0 with data_out=0x05 in cycle 3; push_d1 with 0x12 in cycle 4; cnt_vc0=2.
// - Both FIFOs hold 3 words, guard off -> three pop_vc0, then three pop_vc1;
//   cnt_vc0=3, cnt_vc1=3; idle=1 after the last push.
// - Streaming VC0, d1_pause high for 4 cycles -> pops stop the same cycle;
//   <=2 pushes complete; popping resumes the cycle after deassert with no word lost or duplicated.
// - Guard on, STARVE_LIMIT=4, both FIFOs hold 10 words -> pop order VC0x4, VC1, VC0x4, VC1, VC0x2, then VC1x8.
// - Reset asserted the cycle after a pop -> no push on the following cycle; cnt_* = 0.
// - 256 VC0 words with CNT_WIDTH=8 -> cnt_vc0 wraps to 0.

Source files
------------

// File: rtl/vc_pop_arbiter.sv
// VC0/VC1 read-side pop arbiter with destination routing and per-VC counters.
// Optional VC1 anti-starvation guard: define VC1_STARVE_GUARD_EN.
module vc_pop_arbiter #(
  parameter int DATA_WIDTH   = 6,
  parameter int DEST_BIT     = 4,
  parameter int CNT_WIDTH    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vc0_empty,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic                  vc1_empty,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  input  logic                  d0_pause,
  input  logic                  d1_pause,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]  cnt_vc0,
  output logic [CNT_WIDTH-1:0]  cnt_vc1,
  output logic                  idle
);

  if (DEST_BIT >= DATA_WIDTH || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("vc_pop_arbiter: bad DEST_BIT or STARVE_LIMIT");
  end

  logic pause_any;
  logic force_vc1;

  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_src_q, rd_src_d;
  logic                  push_d0_q, push_d0_d;
  logic                  push_d1_q, push_d1_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;
  logic [DATA_WIDTH-1:0] sel;

  assign pause_any = d0_pause | d1_pause;

  assign pop_vc0 = !reset & !pause_any
                 & !vc0_empty & !force_vc1;
  assign pop_vc1 = !reset & !pause_any
                 & !vc1_empty
                 & (vc0_empty | force_vc1);

`ifdef VC1_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;

  assign force_vc1 = (starve_q == SW'(STARVE_LIMIT))
                   & !vc1_empty;

  // Pause cycles pop nothing, so the count holds.
  always_comb begin
    starve_d = starve_q;
    if (vc1_empty || pop_vc1) begin
      starve_d = '0;
    end else if (pop_vc0) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_vc1 = 1'b0;
`endif

  assign sel = rd_src_q ? vc1_data : vc0_data;

  always_comb begin
    rd_valid_d = pop_vc0 | pop_vc1;
    rd_src_d   = pop_vc1;
    push_d0_d  = 1'b0;
    push_d1_d  = 1'b0;
    data_d     = data_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    if (rd_valid_q) begin
      data_d    = sel;
      push_d0_d = !sel[DEST_BIT];
      push_d1_d = sel[DEST_BIT];
      if (rd_src_q) begin
        cnt1_d = cnt1_q + CNT_WIDTH'(1);
      end else begin
        cnt0_d = cnt0_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_src_q   <= 1'b0;
      push_d0_q  <= 1'b0;
      push_d1_q  <= 1'b0;
      data_q     <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_src_q   <= rd_src_d;
      push_d0_q  <= push_d0_d;
      push_d1_q  <= push_d1_d;
      data_q     <= data_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  assign push_d0  = push_d0_q;
  assign push_d1  = push_d1_q;
  assign data_out = data_q;
  assign cnt_vc0  = cnt0_q;
  assign cnt_vc1  = cnt1_q;

  // Reset reports idle even when the FIFOs hold words.
  assign idle = reset
              | (vc0_empty & vc1_empty
                 & !rd_valid_q
                 & !push_d0_q & !push_d1_q);

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Scoreboard bench for vc_pop_arbiter with behavioural VC FIFO models.
module tb_vc_pop_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       vc0_empty, vc1_empty;
  logic [5:0] vc0_data, vc1_data;
  logic       d0_pause, d1_pause;
  logic       pop_vc0, pop_vc1;
  logic       push_d0, push_d1;
  logic [5:0] data_out;
  logic [7:0] cnt_vc0, cnt_vc1;
  logic       idle;

  vc_pop_arbiter dut (
    .clk(clk), .reset(reset),
    .vc0_empty(vc0_empty), .vc0_data(vc0_data),
    .vc1_empty(vc1_empty), .vc1_data(vc1_data),
    .d0_pause(d0_pause), .d1_pause(d1_pause),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .push_d0(push_d0), .push_d1(push_d1),
    .data_out(data_out),
    .cnt_vc0(cnt_vc0), .cnt_vc1(cnt_vc1),
    .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dest;
    logic [5:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  int         exp_pop[$];
  bit         chk_pop = 0;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         push_cnt = 0;
  int         first_pop = -1;
  int         first_push = -1;
  bit         p0_l = 0;
  bit         p1_l = 0;

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic load0(logic [5:0] w);
    q0.push_back(w);
    vc0_empty = 1'b0;
  endtask

  task automatic load1(logic [5:0] w);
    q1.push_back(w);
    vc1_empty = 1'b0;
  endtask

  task automatic expect_w(logic [5:0] w, logic dst);
    exp_t e;
    e.dest = dst;
    e.data = w;
    sb.push_back(e);
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(idle && sb.size() == 0) && n < budget);
    if (n >= budget) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // VC FIFO models: read data appears the cycle after a pop.
  always @(posedge clk) begin
    #1;
    if (p0_l && q0.size() > 0) vc0_data = q0.pop_front();
    if (p1_l && q1.size() > 0) vc1_data = q1.pop_front();
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    p0_l = pop_vc0;
    p1_l = pop_vc1;
    if (pop_vc0 && pop_vc1) chk("pop_excl", 1, 0);
    if ((pop_vc0 || pop_vc1) && first_pop < 0)
      first_pop = cyc;
    if (chk_pop && (pop_vc0 || pop_vc1)) begin
      if (exp_pop.size() == 0) chk("pop_extra", 1, 0);
      else chk("pop_order", pop_vc1, exp_pop.pop_front());
    end
    if (push_d0 || push_d1) begin
      push_cnt++;
      if (first_push < 0) first_push = cyc;
      if (sb.size() == 0) begin
        chk("push_unexp", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("push_onehot", push_d0 ^ push_d1, 1);
        chk("push_dest", push_d1, e.dest);
        chk("push_data", data_out, e.data);
      end
    end
  end

  int seq[$];
  logic [5:0] w0[10];
  logic [5:0] w1[10];

  initial begin
    reset = 1'b1;
    d0_pause = 1'b0;
    d1_pause = 1'b0;
    vc0_empty = 1'b1;
    vc1_empty = 1'b1;
    vc0_data = '0;
    vc1_data = '0;
    @(posedge clk);
    #2;
    load0(6'h3f);
    load1(6'h2a);
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      chk("rst_pop0", pop_vc0, 0);
      chk("rst_pop1", pop_vc1, 0);
      chk("rst_push0", push_d0, 0);
      chk("rst_push1", push_d1, 0);
      chk("rst_data", data_out, 0);
      chk("rst_cnt0", cnt_vc0, 0);
      chk("rst_cnt1", cnt_vc1, 0);
      chk("rst_idle", idle, 1);
    end
    step();
    q0.delete();
    q1.delete();
    vc0_empty = 1'b1;
    vc1_empty = 1'b1;
    reset = 1'b0;

    // Two VC0 words, one per destination, latency 2
    step();
    first_pop = -1;
    first_push = -1;
    expect_w(6'h05, 1'b0);
    expect_w(6'h12, 1'b1);
    load0(6'h05);
    load0(6'h12);
    @(negedge clk);
    chk("t2_pop0", pop_vc0, 1);
    wait_idle(50);
    chk("t2_lat", first_push - first_pop, 2);
    chk("t2_cnt0", cnt_vc0, 2);
    chk("t2_cnt1", cnt_vc1, 0);

    // VC0 priority over VC1
    do_reset();
    expect_w(6'h01, 1'b0);
    expect_w(6'h13, 1'b1);
    expect_w(6'h20, 1'b0);
    expect_w(6'h31, 1'b1);
    expect_w(6'h0a, 1'b0);
    expect_w(6'h1f, 1'b1);
    exp_pop = '{0, 0, 0, 1, 1, 1};
    chk_pop = 1;
    load0(6'h01); load0(6'h13); load0(6'h20);
    load1(6'h31); load1(6'h0a); load1(6'h1f);
    wait_idle(50);
    chk_pop = 0;
    chk("t3_order_left", exp_pop.size(), 0);
    chk("t3_cnt0", cnt_vc0, 3);
    chk("t3_cnt1", cnt_vc1, 3);
    chk("t3_idle", idle, 1);

    // Pause mid-stream
    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic [5:0] w;
      w = 6'(i * 5);
      expect_w(w, w[4]);
      load0(w);
    end
    step(2);
    d1_pause = 1'b1;
    begin
      int pc;
      pc = push_cnt;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) step();
        @(negedge clk);
        chk("t4_pause_pop", pop_vc0, 0);
      end
      step();
      d1_pause = 1'b0;
      @(negedge clk);
      chk("t4_resume", pop_vc0, 1);
      chk("t4_drain", push_cnt - pc, 2);
    end
    wait_idle(50);
    chk("t4_cnt0", cnt_vc0, 8);

    // Ten words on each VC
    do_reset();
`ifdef VC1_STARVE_GUARD_EN
    seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1,
            0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
`else
    seq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
            1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
    for (int i = 0; i < 10; i++) begin
      w0[i] = 6'(i * 3);
      w1[i] = 6'(40 + i * 2);
    end
    begin
      int i0 = 0;
      int i1 = 0;
      foreach (seq[k]) begin
        exp_pop.push_back(seq[k]);
        if (seq[k] == 0) begin
          expect_w(w0[i0], w0[i0][4]);
          i0++;
        end else begin
          expect_w(w1[i1], w1[i1][4]);
          i1++;
        end
      end
    end
    chk_pop = 1;
    for (int i = 0; i < 10; i++) begin
      load0(w0[i]);
      load1(w1[i]);
    end
    wait_idle(100);
    chk_pop = 0;
    chk("t5_order_left", exp_pop.size(), 0);
    chk("t5_cnt0", cnt_vc0, 10);
    chk("t5_cnt1", cnt_vc1, 10);

    // Reset the cycle after a pop discards the word
    do_reset();
    load0(6'h07);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("t6_pop_rst", pop_vc0, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_push0", push_d0, 0);
    chk("t6_push1", push_d1, 0);
    chk("t6_cnt0", cnt_vc0, 0);
    step(2);

    // Counter wrap after 256 words
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [5:0] w;
      w = 6'(i);
      expect_w(w, w[4]);
      load0(w);
    end
    step(130);
    @(negedge clk);
    chk("t7_cnt_mid_nz", cnt_vc0 != 0, 1);
    wait_idle(600);
    chk("t7_wrap", cnt_vc0, 0);
    chk("t7_cnt1", cnt_vc1, 0);
    chk("t7_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
